load_align_unit: RTL and testbench

- Parametrised load-datapath successor for the MEM/WB stage.
- Accepts one load request at a time and issues one or two aligned word reads on a valid/ready memory port.
- Merges split beats for misaligned accesses, selects the addressed byte, halfword, word or doubleword, then sign- or zero-extends to XLEN.
- Returns the result on a held valid/ready response port; supports RV32 and RV64 load encodings.

---
 rtl/load_align_unit.sv | 196 +++++++++++++++++++
 tb/tb_load_align_unit.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// ============================================================================
// load_align_unit
//
// Load datapath for the MEM/WB stage. Accepts one load request at a time,
// issues one or two word-aligned reads on a valid/ready memory port, merges
// the beats of a misaligned access, selects the addressed byte, halfword,
// word or doubleword and sign- or zero-extends it to XLEN. The result is
// presented on a valid/ready response port and held until it is accepted.
//
// Parameters:
//   XLEN           datapath / memory word width (32 or 64)
//   ADDR_W         byte-address width
//   MISALIGN_SPLIT 1 = misaligned loads use two beats, 0 = they return err
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   ld_req_valid/ready           load request handshake (ready only in IDLE)
//   ld_req_addr, ld_req_func3    byte address and RISC-V load func3
//   mem_req_valid/ready          memory read request handshake
//   mem_req_addr                 word-aligned read address
//   mem_rsp_valid, mem_rsp_data  read data return
//   ld_rsp_valid/ready           load response handshake
//   ld_rsp_data, ld_rsp_err      extended result, error flag (data = 0)
// ============================================================================
module load_align_unit #(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [ADDR_W-1:0] ld_req_addr,
    input  logic [2:0]        ld_req_func3,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_data,
    output logic              ld_rsp_valid,
    input  logic              ld_rsp_ready,
    output logic [XLEN-1:0]   ld_rsp_data,
    output logic              ld_rsp_err
);

    localparam int BYTES = XLEN / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [ADDR_W-1:0]   r_base;
    logic [OFF_W-1:0]    r_off;
    logic [3:0]          r_size;
    logic                r_signed;
    logic                r_mis;
    logic                r_err;
    logic [XLEN-1:0]     r_lo;
    logic [XLEN-1:0]     r_hi;

    logic [3:0]          w_size;
    logic                w_legal;
    logic                w_signed;
    logic [OFF_W-1:0]    w_off;
    logic [4:0]          w_end;
    logic                w_mis;
    logic                w_err;
    logic [ADDR_W-1:0]   w_base;

    logic [XLEN-1:0]     w_low;
    logic [XLEN-1:0]     w_mask;
    logic                w_sign;
    logic [XLEN-1:0]     w_result;

    // Request decode. LW is flagged signed on both widths: on XLEN=32 the
    // full-width mask makes sign extension a no-op, so one path serves both.
    always_comb begin
        w_size   = 4'd1;
        w_legal  = 1'b1;
        w_signed = 1'b0;
        case (ld_req_func3)
            3'b000: begin w_size = 4'd1; w_signed = 1'b1; end
            3'b100: begin w_size = 4'd1; end
            3'b001: begin w_size = 4'd2; w_signed = 1'b1; end
            3'b101: begin w_size = 4'd2; end
            3'b010: begin w_size = 4'd4; w_signed = 1'b1; end
            3'b110: begin w_size = 4'd4; w_legal = (XLEN == 64); end
            3'b011: begin w_size = 4'd8; w_legal = (XLEN == 64); end
            default: begin w_legal = 1'b0; end
        endcase
    end

    assign w_off  = ld_req_addr[OFF_W-1:0];
    assign w_end  = 5'(w_off) + 5'(w_size);
    assign w_mis  = (w_end > 5'(BYTES));
    assign w_err  = !w_legal || (w_mis && (MISALIGN_SPLIT == 0));
    assign w_base = {ld_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (ld_req_valid)  w_next = w_err ? RESP : REQ0;
            REQ0:    if (mem_req_ready) w_next = WAIT0;
            WAIT0:   if (mem_rsp_valid) w_next = r_mis ? REQ1 : RESP;
            REQ1:    if (mem_req_ready) w_next = WAIT1;
            WAIT1:   if (mem_rsp_valid) w_next = RESP;
            RESP:    if (ld_rsp_ready)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request capture and beat registers. The high beat is cleared on every
    // accepted request so single-beat loads merge against zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base   <= '0;
            r_off    <= '0;
            r_size   <= 4'd0;
            r_signed <= 1'b0;
            r_mis    <= 1'b0;
            r_err    <= 1'b0;
            r_lo     <= '0;
            r_hi     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ld_req_valid) begin
                        r_base   <= w_base;
                        r_off    <= w_off;
                        r_size   <= w_size;
                        r_signed <= w_signed;
                        r_mis    <= w_mis;
                        r_err    <= w_err;
                        r_hi     <= '0;
                    end
                end
                WAIT0: if (mem_rsp_valid) r_lo <= mem_rsp_data;
                WAIT1: if (mem_rsp_valid) r_hi <= mem_rsp_data;
                default: ;
            endcase
        end
    end

    // Byte selection: shift the merged {hi, lo} pair down by the byte offset,
    // then mask to the access size and fill the upper bits with the sign bit
    // when the access is signed.
    always_comb begin
        w_low  = XLEN'({r_hi, r_lo} >> {r_off, 3'b000});
        w_mask = '1;
        w_sign = 1'b0;
        case (r_size)
            4'd1:    begin w_mask = XLEN'(8'hFF);         w_sign = w_low[7];  end
            4'd2:    begin w_mask = XLEN'(16'hFFFF);      w_sign = w_low[15]; end
            4'd4:    begin w_mask = XLEN'(32'hFFFF_FFFF); w_sign = w_low[31]; end
            default: begin w_mask = '1;                   w_sign = 1'b0;      end
        endcase
        w_result = (w_low & w_mask) | ((r_signed && w_sign) ? ~w_mask : '0);
    end

    // Outputs are decoded from the state so that every handshake signal and
    // address is stable for as long as the state is held.
    always_comb begin
        ld_req_ready  = (r_state == IDLE);
        mem_req_valid = (r_state == REQ0) || (r_state == REQ1);
        mem_req_addr  = '0;
        if (r_state == REQ0) begin
            mem_req_addr = r_base;
        end else if (r_state == REQ1) begin
            mem_req_addr = r_base + ADDR_W'(BYTES);
        end
        ld_rsp_valid = (r_state == RESP);
        ld_rsp_err   = (r_state == RESP) && r_err;
        ld_rsp_data  = ((r_state == RESP) && !r_err) ? w_result : '0;
    end

endmodule

// File: tb/tb_load_align_unit.sv
// ============================================================================
// tb_load_align_unit
//
// Directed bench for load_align_unit. Three instances share clock and reset:
//   a: XLEN=32, MISALIGN_SPLIT=1   b: XLEN=32, MISALIGN_SPLIT=0
//   c: XLEN=64, MISALIGN_SPLIT=1
// Each instance has a small memory responder that returns the read data in
// the cycle after the request handshake.
// ============================================================================
module tb_load_align_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int total = 0;
    int bad   = 0;

    // Instance a
    logic        aReqValid = 1'b0;
    logic        aReqReady;
    logic [31:0] aReqAddr = 32'h0;
    logic [2:0]  aFunc3 = 3'b0;
    logic        aMemReqValid;
    logic        aMemReqReady = 1'b1;
    logic [31:0] aMemReqAddr;
    logic        aMemRspValid = 1'b0;
    logic [31:0] aMemRspData = 32'h0;
    logic        aLdRspValid;
    logic        aLdRspReady = 1'b0;
    logic [31:0] aLdRspData;
    logic        aLdRspErr;
    logic        aHold = 1'b0;
    logic        aPend = 1'b0;
    logic [31:0] aPendAddr = 32'h0;
    int          aReqCount = 0;
    logic [31:0] aLastAddr = 32'h0;
    logic [31:0] aPrevAddr = 32'h0;

    // Instance b
    logic        bReqValid = 1'b0;
    logic        bReqReady;
    logic [31:0] bReqAddr = 32'h0;
    logic [2:0]  bFunc3 = 3'b0;
    logic        bMemReqValid;
    logic        bMemReqReady = 1'b1;
    logic [31:0] bMemReqAddr;
    logic        bMemRspValid = 1'b0;
    logic [31:0] bMemRspData = 32'h0;
    logic        bLdRspValid;
    logic        bLdRspReady = 1'b0;
    logic [31:0] bLdRspData;
    logic        bLdRspErr;
    logic        bPend = 1'b0;
    logic [31:0] bPendAddr = 32'h0;
    int          bReqCount = 0;

    // Instance c
    logic        cReqValid = 1'b0;
    logic        cReqReady;
    logic [31:0] cReqAddr = 32'h0;
    logic [2:0]  cFunc3 = 3'b0;
    logic        cMemReqValid;
    logic        cMemReqReady = 1'b1;
    logic [31:0] cMemReqAddr;
    logic        cMemRspValid = 1'b0;
    logic [63:0] cMemRspData = 64'h0;
    logic        cLdRspValid;
    logic        cLdRspReady = 1'b0;
    logic [63:0] cLdRspData;
    logic        cLdRspErr;
    logic        cPend = 1'b0;
    logic [31:0] cPendAddr = 32'h0;

    load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) uDutA (
        .clk(clk), .rst_n(rst_n),
        .ld_req_valid(aReqValid), .ld_req_ready(aReqReady),
        .ld_req_addr(aReqAddr), .ld_req_func3(aFunc3),
        .mem_req_valid(aMemReqValid), .mem_req_ready(aMemReqReady),
        .mem_req_addr(aMemReqAddr),
        .mem_rsp_valid(aMemRspValid), .mem_rsp_data(aMemRspData),
        .ld_rsp_valid(aLdRspValid), .ld_rsp_ready(aLdRspReady),
        .ld_rsp_data(aLdRspData), .ld_rsp_err(aLdRspErr)
    );

    load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) uDutB (
        .clk(clk), .rst_n(rst_n),
        .ld_req_valid(bReqValid), .ld_req_ready(bReqReady),
        .ld_req_addr(bReqAddr), .ld_req_func3(bFunc3),
        .mem_req_valid(bMemReqValid), .mem_req_ready(bMemReqReady),
        .mem_req_addr(bMemReqAddr),
        .mem_rsp_valid(bMemRspValid), .mem_rsp_data(bMemRspData),
        .ld_rsp_valid(bLdRspValid), .ld_rsp_ready(bLdRspReady),
        .ld_rsp_data(bLdRspData), .ld_rsp_err(bLdRspErr)
    );

    load_align_unit #(.XLEN(64), .ADDR_W(32), .MISALIGN_SPLIT(1)) uDutC (
        .clk(clk), .rst_n(rst_n),
        .ld_req_valid(cReqValid), .ld_req_ready(cReqReady),
        .ld_req_addr(cReqAddr), .ld_req_func3(cFunc3),
        .mem_req_valid(cMemReqValid), .mem_req_ready(cMemReqReady),
        .mem_req_addr(cMemReqAddr),
        .mem_rsp_valid(cMemRspValid), .mem_rsp_data(cMemRspData),
        .ld_rsp_valid(cLdRspValid), .ld_rsp_ready(cLdRspReady),
        .ld_rsp_data(cLdRspData), .ld_rsp_err(cLdRspErr)
    );

    always #5 clk = ~clk;

    // Memory images
    function automatic logic [31:0] mem32(input logic [31:0] addr);
        case (addr)
            32'h0000_0100: return 32'h80F1_7F02;
            32'h0000_0200: return 32'h4433_2211;
            32'h0000_0204: return 32'h8877_6655;
            32'hFFFF_FFFC: return 32'hA1B2_C3D4;
            32'h0000_0000: return 32'h1122_3344;
            default:       return 32'h0;
        endcase
    endfunction

    function automatic logic [63:0] mem64(input logic [31:0] addr);
        if (addr == 32'h0) return 64'h8000_0000_FFFF_FFFE;
        return 64'h0;
    endfunction

    // Memory responders: a handshake seen in one cycle produces read data
    // in the next cycle. Responder a can withhold data while aHold is set.
    always @(negedge clk) begin
        if (aHold) begin
            aMemRspValid = 1'b0;
        end else begin
            aMemRspValid = aPend;
            aMemRspData  = mem32(aPendAddr);
            aPend        = 1'b0;
        end
        if (aMemReqValid && aMemReqReady) begin
            aPend     = 1'b1;
            aPendAddr = aMemReqAddr;
            aPrevAddr = aLastAddr;
            aLastAddr = aMemReqAddr;
            aReqCount++;
        end
    end

    always @(negedge clk) begin
        bMemRspValid = bPend;
        bMemRspData  = mem32(bPendAddr);
        bPend        = 1'b0;
        if (bMemReqValid && bMemReqReady) begin
            bPend     = 1'b1;
            bPendAddr = bMemReqAddr;
            bReqCount++;
        end
    end

    always @(negedge clk) begin
        cMemRspValid = cPend;
        cMemRspData  = mem64(cPendAddr);
        cPend        = 1'b0;
        if (cMemReqValid && cMemReqReady) begin
            cPend     = 1'b1;
            cPendAddr = cMemReqAddr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int w, input logic v, input logic [31:0] addr, input logic [2:0] f3);
        case (w)
            0: begin aReqValid = v; aReqAddr = addr; aFunc3 = f3; end
            1: begin bReqValid = v; bReqAddr = addr; bFunc3 = f3; end
            default: begin cReqValid = v; cReqAddr = addr; cFunc3 = f3; end
        endcase
    endtask

    task automatic setRspReady(input int w, input logic v);
        case (w)
            0: aLdRspReady = v;
            1: bLdRspReady = v;
            default: cLdRspReady = v;
        endcase
    endtask

    function automatic logic getValid(input int w);
        case (w)
            0: return aLdRspValid;
            1: return bLdRspValid;
            default: return cLdRspValid;
        endcase
    endfunction

    function automatic logic [63:0] getData(input int w);
        case (w)
            0: return {32'h0, aLdRspData};
            1: return {32'h0, bLdRspData};
            default: return cLdRspData;
        endcase
    endfunction

    function automatic logic getErr(input int w);
        case (w)
            0: return aLdRspErr;
            1: return bLdRspErr;
            default: return cLdRspErr;
        endcase
    endfunction

    // One complete load: cycles counts clock edges from the acceptance edge
    // up to the first cycle in which the response is visible.
    task automatic doLoad(input int w, input logic [31:0] addr, input logic [2:0] f3,
                          output logic [63:0] data, output logic err, output int cycles);
        applyStimulus(w, 1'b1, addr, f3);
        tick();
        applyStimulus(w, 1'b0, 32'h0, 3'b000);
        cycles = 1;
        while (!getValid(w) && cycles < 50) begin
            tick();
            cycles++;
        end
        data = getData(w);
        err  = getErr(w);
        setRspReady(w, 1'b1);
        tick();
        setRspReady(w, 1'b0);
    endtask

    initial begin
        logic [63:0] d;
        logic        e;
        int          cyc;
        int          base;
        int          n;
        logic        saw;

        $display("[TB] start");
        rst_n = 1'b0;
        tick();
        tick();
        checkOutput("rst_ld_req_ready",  64'(aReqReady),    64'd1);
        checkOutput("rst_mem_req_valid", 64'(aMemReqValid), 64'd0);
        checkOutput("rst_mem_req_addr",  64'(aMemReqAddr),  64'd0);
        checkOutput("rst_ld_rsp_valid",  64'(aLdRspValid),  64'd0);
        checkOutput("rst_ld_rsp_data",   64'(aLdRspData),   64'd0);
        checkOutput("rst_ld_rsp_err",    64'(aLdRspErr),    64'd0);
        rst_n = 1'b1;
        tick();

        // Byte/halfword selection on XLEN=32
        doLoad(0, 32'h101, 3'b000, d, e, cyc);
        checkOutput("lb_101_data", d, 64'h0000_007F);
        checkOutput("lb_101_err", 64'(e), 64'd0);
        checkOutput("lb_101_latency", 64'(cyc), 64'd3);
        doLoad(0, 32'h103, 3'b000, d, e, cyc);
        checkOutput("lb_103_data", d, 64'hFFFF_FF80);
        doLoad(0, 32'h103, 3'b100, d, e, cyc);
        checkOutput("lbu_103_data", d, 64'h0000_0080);
        doLoad(0, 32'h102, 3'b101, d, e, cyc);
        checkOutput("lhu_102_data", d, 64'h0000_80F1);

        // Split word and halfword
        base = aReqCount;
        doLoad(0, 32'h203, 3'b010, d, e, cyc);
        checkOutput("lw_203_reqs", 64'(aReqCount - base), 64'd2);
        checkOutput("lw_203_addr0", 64'(aPrevAddr), 64'h200);
        checkOutput("lw_203_addr1", 64'(aLastAddr), 64'h204);
        checkOutput("lw_203_data", d, 64'h7766_5544);
        checkOutput("lw_203_err", 64'(e), 64'd0);
        checkOutput("lw_203_latency", 64'(cyc), 64'd5);
        doLoad(0, 32'h203, 3'b001, d, e, cyc);
        checkOutput("lh_203_data", d, 64'h0000_5544);

        // LD is illegal on XLEN=32
        base = aReqCount;
        doLoad(0, 32'h100, 3'b011, d, e, cyc);
        checkOutput("ld_x32_err", 64'(e), 64'd1);
        checkOutput("ld_x32_data", d, 64'd0);
        checkOutput("ld_x32_latency", 64'(cyc), 64'd1);
        checkOutput("ld_x32_reqs", 64'(aReqCount - base), 64'd0);

        // Misaligned with splitting disabled
        base = bReqCount;
        doLoad(1, 32'h202, 3'b010, d, e, cyc);
        checkOutput("nosplit_err", 64'(e), 64'd1);
        checkOutput("nosplit_data", d, 64'd0);
        checkOutput("nosplit_latency", 64'(cyc), 64'd1);
        checkOutput("nosplit_reqs", 64'(bReqCount - base), 64'd0);

        // XLEN=64 word/doubleword extension
        doLoad(2, 32'h0, 3'b010, d, e, cyc);
        checkOutput("x64_lw_data", d, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("x64_lw_latency", 64'(cyc), 64'd3);
        doLoad(2, 32'h0, 3'b110, d, e, cyc);
        checkOutput("x64_lwu_data", d, 64'h0000_0000_FFFF_FFFE);
        doLoad(2, 32'h0, 3'b011, d, e, cyc);
        checkOutput("x64_ld_data", d, 64'h8000_0000_FFFF_FFFE);
        checkOutput("x64_ld_err", 64'(e), 64'd0);

        // Split access wrapping past the top of the address space
        base = aReqCount;
        doLoad(0, 32'hFFFF_FFFE, 3'b010, d, e, cyc);
        checkOutput("wrap_reqs", 64'(aReqCount - base), 64'd2);
        checkOutput("wrap_addr0", 64'(aPrevAddr), 64'hFFFF_FFFC);
        checkOutput("wrap_addr1", 64'(aLastAddr), 64'h0);
        checkOutput("wrap_data", d, 64'h3344_A1B2);

        // Memory request backpressure
        aMemReqReady = 1'b0;
        checkOutput("bp_ready_before", 64'(aReqReady), 64'd1);
        applyStimulus(0, 1'b1, 32'h101, 3'b000);
        tick();
        applyStimulus(0, 1'b0, 32'h0, 3'b000);
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp_mem_valid", 64'(aMemReqValid), 64'd1);
            checkOutput("bp_mem_addr", 64'(aMemReqAddr), 64'h100);
            checkOutput("bp_ld_req_ready", 64'(aReqReady), 64'd0);
            tick();
        end
        aMemReqReady = 1'b1;
        n = 0;
        while (!aLdRspValid && n < 20) begin
            tick();
            n++;
        end
        checkOutput("bp_rsp_arrived", 64'(aLdRspValid), 64'd1);

        // Response backpressure
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_rsp_valid", 64'(aLdRspValid), 64'd1);
            checkOutput("bp_rsp_data", 64'(aLdRspData), 64'h7F);
            checkOutput("bp_rsp_err", 64'(aLdRspErr), 64'd0);
            checkOutput("bp_rsp_req_ready", 64'(aReqReady), 64'd0);
            tick();
        end
        aLdRspReady = 1'b1;
        tick();
        aLdRspReady = 1'b0;
        checkOutput("bp_rsp_done", 64'(aLdRspValid), 64'd0);
        checkOutput("bp_idle_ready", 64'(aReqReady), 64'd1);

        // Reset during WAIT1 with the second beat withheld
        applyStimulus(0, 1'b1, 32'h203, 3'b010);
        tick();
        applyStimulus(0, 1'b0, 32'h0, 3'b000);
        tick();
        tick();
        aHold = 1'b1;
        tick();
        tick();
        checkOutput("wait1_mem_valid", 64'(aMemReqValid), 64'd0);
        checkOutput("wait1_req_ready", 64'(aReqReady), 64'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ld_req_ready",  64'(aReqReady),    64'd1);
        checkOutput("midrst_mem_req_valid", 64'(aMemReqValid), 64'd0);
        checkOutput("midrst_mem_req_addr",  64'(aMemReqAddr),  64'd0);
        checkOutput("midrst_ld_rsp_valid",  64'(aLdRspValid),  64'd0);
        checkOutput("midrst_ld_rsp_data",   64'(aLdRspData),   64'd0);
        checkOutput("midrst_ld_rsp_err",    64'(aLdRspErr),    64'd0);
        tick();
        rst_n = 1'b1;
        aHold = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (aLdRspValid) saw = 1'b1;
        end
        checkOutput("midrst_no_response", 64'(saw), 64'd0);
        checkOutput("midrst_idle", 64'(aReqReady), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
